// File: rtl/ring_prbs_pkg.sv
// Shared definitions for the lfsr7 ring traffic generator and checker:
// word width, lock-up value, next-word function and checker state encoding.
package ring_prbs_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 8'h7F;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } chk_state_e;

    function automatic logic [LFSR_W-1:0] lfsr7_nxt(input logic [LFSR_W-1:0] s);
        return {1'b0, s[5:0], ~(s[4] ^ s[2])};
    endfunction

    // A word can only come from the generator if bit 7 is clear and it is not the lock-up value.
    function automatic logic lfsr7_legal(input logic [LFSR_W-1:0] s);
        return (s[LFSR_W-1] == 1'b0) && (s != LFSR_LOCKUP);
    endfunction

endpackage

// File: rtl/lfsr7_checker.sv
// Receive-side lfsr7 stream checker: seeds from incoming words, locks after a
// run of matches, then compares against a free-running local generator.
module lfsr7_checker
    import ring_prbs_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              in_valid_i,
    input  logic [LFSR_W-1:0] in_data_i,
    output logic              locked_o,
    output logic              err_pulse_o,
    output logic [CNT_W-1:0]  err_count_o,
    output logic [CNT_W-1:0]  word_count_o,
    output logic [LFSR_W-1:0] exp_data_o
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    chk_state_e        state_q, state_d;
    logic [LFSR_W-1:0] exp_q, exp_d;
    logic [MW-1:0]     matchCnt_q, matchCnt_d;
    logic [LW-1:0]     missCnt_q, missCnt_d;
    logic              errPulse_q;
    logic [CNT_W-1:0]  errCnt_q, wordCnt_q;
    logic              errHit, wordHit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= SEARCH;
            exp_q      <= '0;
            matchCnt_q <= '0;
            missCnt_q  <= '0;
            errPulse_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            matchCnt_q <= matchCnt_d;
            missCnt_q  <= missCnt_d;
            errPulse_q <= errHit;
        end
    end

    // Idle cycles fall through with every register holding its value.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        matchCnt_d = matchCnt_q;
        missCnt_d  = missCnt_q;
        errHit     = 1'b0;
        wordHit    = 1'b0;
        if (in_valid_i) begin
            unique case (state_q)
                SEARCH: begin
                    if (lfsr7_legal(in_data_i)) begin
                        exp_d      = lfsr7_nxt(in_data_i);
                        matchCnt_d = '0;
                        state_d    = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (in_data_i == exp_q) begin
                        exp_d = lfsr7_nxt(in_data_i);
                        if (matchCnt_q + MW'(1) == MW'(LOCK_CNT)) begin
                            matchCnt_d = '0;
                            missCnt_d  = '0;
                            state_d    = LOCKED;
                        end else begin
                            matchCnt_d = matchCnt_q + MW'(1);
                        end
                    end else if (lfsr7_legal(in_data_i)) begin
                        exp_d      = lfsr7_nxt(in_data_i);
                        matchCnt_d = '0;
                    end else begin
                        exp_d      = '0;
                        matchCnt_d = '0;
                        state_d    = SEARCH;
                    end
                end
                LOCKED: begin
                    // Once locked the received data never reseeds the local generator.
                    exp_d   = lfsr7_nxt(exp_q);
                    wordHit = 1'b1;
                    if (in_data_i == exp_q) begin
                        missCnt_d = '0;
                    end else begin
                        errHit = 1'b1;
                        if (missCnt_q + LW'(1) == LW'(LOSS_CNT)) begin
                            exp_d     = '0;
                            missCnt_d = '0;
                            state_d   = SEARCH;
                        end else begin
                            missCnt_d = missCnt_q + LW'(1);
                        end
                    end
                end
                default: begin
                    exp_d   = '0;
                    state_d = SEARCH;
                end
            endcase
        end
    end

    // clr takes priority over a same-cycle count; both counters stick at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            errCnt_q <= '0;
        end else if (clr_i) begin
            errCnt_q <= '0;
        end else if (errHit && (errCnt_q != '1)) begin
            errCnt_q <= errCnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wordCnt_q <= '0;
        end else if (clr_i) begin
            wordCnt_q <= '0;
        end else if (wordHit && (wordCnt_q != '1)) begin
            wordCnt_q <= wordCnt_q + CNT_W'(1);
        end
    end

    assign locked_o     = (state_q == LOCKED);
    assign err_pulse_o  = errPulse_q;
    assign err_count_o  = errCnt_q;
    assign word_count_o = wordCnt_q;
    assign exp_data_o   = exp_q;

endmodule

// File: tb/tb_lfsr7_checker.sv
// Self-checking bench for lfsr7_checker: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the checker.
module tb_lfsr7_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rstN;
    logic             clr;
    logic             inValid;
    logic [7:0]       inData;
    logic             locked;
    logic             errPulse;
    logic [CNT_W-1:0] errCount;
    logic [CNT_W-1:0] wordCount;
    logic [7:0]       expData;

    int checks = 0;
    int errors = 0;

    // Model state: phase 0 = hunting for a seed, 1 = confirming, 2 = locked.
    int mPhase, mExp, mRun, mMiss, mErr, mWords;
    bit mPulse;

    lfsr7_checker #(
        .LOCK_CNT(LOCK_CNT),
        .LOSS_CNT(LOSS_CNT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .clr_i       (clr),
        .in_valid_i  (inValid),
        .in_data_i   (inData),
        .locked_o    (locked),
        .err_pulse_o (errPulse),
        .err_count_o (errCount),
        .word_count_o(wordCount),
        .exp_data_o  (expData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int refNext(input int s);
        int b4 = (s / 16) % 2;
        int b2 = (s / 4) % 2;
        return (s % 64) * 2 + ((b4 == b2) ? 1 : 0);
    endfunction

    function automatic bit refLegal(input int s);
        return (s < 128) && (s != 127);
    endfunction

    function automatic int bump(input int c);
        return (c < CNT_MAX) ? c + 1 : c;
    endfunction

    function automatic void modelReset();
        mPhase = 0; mExp = 0; mRun = 0; mMiss = 0; mErr = 0; mWords = 0; mPulse = 0;
    endfunction

    // One clock edge of the intended behaviour.
    function automatic void modelClock(input bit v, input int d, input bit c);
        bit errInc  = 0;
        bit wordInc = 0;
        mPulse = 0;
        if (v) begin
            if (mPhase == 0) begin
                if (refLegal(d)) begin
                    mExp = refNext(d); mRun = 0; mPhase = 1;
                end
            end else if (mPhase == 1) begin
                if (d == mExp) begin
                    mRun++;
                    mExp = refNext(d);
                    if (mRun == LOCK_CNT) begin
                        mPhase = 2; mMiss = 0; mRun = 0;
                    end
                end else if (refLegal(d)) begin
                    mExp = refNext(d); mRun = 0;
                end else begin
                    mPhase = 0; mExp = 0; mRun = 0;
                end
            end else begin
                bit good = (d == mExp);
                wordInc = 1;
                mExp = refNext(mExp);
                if (good) begin
                    mMiss = 0;
                end else begin
                    mPulse = 1; errInc = 1; mMiss++;
                    if (mMiss == LOSS_CNT) begin
                        mPhase = 0; mExp = 0; mMiss = 0;
                    end
                end
            end
        end
        if (c) begin
            mErr = 0; mWords = 0;
        end else begin
            if (errInc)  mErr   = bump(mErr);
            if (wordInc) mWords = bump(mWords);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".locked"},    32'(locked),    (mPhase == 2) ? 1 : 0);
        chk({tag, ".errPulse"},  32'(errPulse),  32'(mPulse));
        chk({tag, ".errCount"},  32'(errCount),  mErr);
        chk({tag, ".wordCount"}, 32'(wordCount), mWords);
        chk({tag, ".expData"},   32'(expData),   mExp);
    endtask

    // Called just after a rising edge: drive, take one edge, then compare.
    task automatic applyStimulus(input bit v, input int d, input bit c, input string tag);
        inValid = v;
        inData  = 8'(d);
        clr     = c;
        @(posedge clk);
        modelClock(v, d, c);
        #1;
        checkOutput(tag);
    endtask

    task automatic doReset();
        rstN = 1'b0; inValid = 1'b0; clr = 1'b0; inData = 8'h00;
        #3;
        modelReset();
        checkOutput("reset");
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic lockFrom(input int seed, input string tag);
        int w = seed;
        for (int i = 0; i <= LOCK_CNT; i++) begin
            applyStimulus(1, w, 0, tag);
            w = refNext(w);
        end
    endtask

    initial begin
        int w;
        rstN = 1'b1; inValid = 1'b0; clr = 1'b0; inData = 8'h00;
        modelReset();
        #2;
        doReset();

        $display("[TB] clean lock");
        applyStimulus(1, 8'h00, 0, "clean");
        applyStimulus(1, 8'h01, 0, "clean");
        applyStimulus(1, 8'h03, 0, "clean");
        applyStimulus(1, 8'h07, 0, "clean");
        chk("cleanNotYet", 32'(locked), 0);
        applyStimulus(1, 8'h0E, 0, "clean");
        chk("cleanLocked", 32'(locked), 1);
        chk("cleanExp", 32'(expData), 32'h1C);
        chk("cleanCounts", 32'(errCount) + 32'(wordCount), 0);

        $display("[TB] single error");
        applyStimulus(1, 8'h1D, 0, "singleErr");
        chk("singlePulse", 32'(errPulse), 1);
        applyStimulus(1, 8'h39, 0, "singleErr");
        chk("singlePulseDrop", 32'(errPulse), 0);
        applyStimulus(1, 8'h72, 0, "singleErr");
        chk("singleErrCount", 32'(errCount), 1);
        chk("singleWordCount", 32'(wordCount), 3);
        chk("singleLocked", 32'(locked), 1);

        $display("[TB] loss of lock");
        applyStimulus(0, 8'h00, 1, "lossClr");
        applyStimulus(1, 8'hFF, 0, "loss");
        applyStimulus(1, 8'hFF, 0, "loss");
        chk("lossStillLocked", 32'(locked), 1);
        applyStimulus(1, 8'hFF, 0, "loss");
        chk("lossUnlocked", 32'(locked), 0);
        chk("lossErrCount", 32'(errCount), 3);
        lockFrom(8'h39, "relock");
        chk("relocked", 32'(locked), 1);

        $display("[TB] lock-up reject");
        for (int i = 0; i < LOSS_CNT; i++) applyStimulus(1, 8'hFF, 0, "toSearch");
        for (int i = 0; i < 20; i++) applyStimulus(1, 8'h7F, 0, "lockup");
        chk("lockupLocked", 32'(locked), 0);
        chk("lockupExp", 32'(expData), 0);

        $display("[TB] gaps and clear");
        doReset();
        w = 8'h00;
        for (int i = 0; i <= LOCK_CNT; i++) begin
            applyStimulus(1, w, 0, "gaps");
            if (i < LOCK_CNT) chk("gapsNotYet", 32'(locked), 0);
            applyStimulus(0, 8'hAA, 0, "gapsIdle");
            w = refNext(w);
        end
        chk("gapsLocked", 32'(locked), 1);
        chk("gapsExp", 32'(expData), 32'h1C);
        applyStimulus(1, 8'h55, 1, "clrMismatch");
        chk("clrErrCount", 32'(errCount), 0);
        chk("clrPulse", 32'(errPulse), 1);

        $display("[TB] random traffic");
        doReset();
        for (int i = 0; i < 800; i++) begin
            int r = int'($urandom_range(0, 99));
            bit c = ($urandom_range(0, 99) < 3);
            if (r < 10)      applyStimulus(0, int'($urandom_range(0, 255)), c, "rand");
            else if (r < 14) applyStimulus(1, int'($urandom_range(127, 255)), c, "rand");
            else if (r < 20) applyStimulus(1, int'($urandom_range(0, 126)), c, "rand");
            else if (mPhase == 0) applyStimulus(1, int'($urandom_range(0, 126)), c, "rand");
            else applyStimulus(1, mExp, c, "rand");
        end

        $display("[TB] saturation");
        doReset();
        lockFrom(int'($urandom_range(0, 126)), "satLock");
        for (int i = 0; i < CNT_MAX + 5; i++) applyStimulus(1, mExp, 0, "sat");
        chk("satWords", 32'(wordCount), CNT_MAX);
        applyStimulus(1, mExp, 1, "satClr");
        chk("satClr", 32'(wordCount), 0);

        $display("[TB] async reset");
        doReset();
        lockFrom(8'h00, "arLock");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, mExp ^ 1, 0, "arErr");
            applyStimulus(1, mExp, 0, "arGood");
        end
        chk("arErrCount", 32'(errCount), 5);
        chk("arLocked", 32'(locked), 1);
        #2;
        rstN = 1'b0;
        #1;
        modelReset();
        checkOutput("asyncReset");
        chk("arCleared", 32'(errCount), 0);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        lockFrom(8'h0E, "postReset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
